// File: rtl/als_pkg.sv
// Shared types and constants for the ALS sample to ASCII byte sequencer.
package als_pkg;

  localparam int SAMPLE_W = 8;
  localparam int BCD_W    = 12;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SEND_C,
    ST_SEND_D,
    ST_SEND_U,
    ST_SEND_CR,
    ST_SEND_LF,
    ST_DONE
  } state_t;

  function automatic logic is_send(input state_t s);
    return (s == ST_SEND_C) || (s == ST_SEND_D) || (s == ST_SEND_U) ||
           (s == ST_SEND_CR) || (s == ST_SEND_LF);
  endfunction

endpackage

// File: rtl/module_bcd2ascii.sv
// Maps one BCD digit (0..9) onto its ASCII character code.
module module_bcd2ascii
  import als_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] ascii_o
);

  assign ascii_o = ASCII_ZERO | {4'b0000, bcd_i};

endmodule

// File: rtl/module_als_ascii_sequencer.sv
// Converts an 8-bit ALS sample to decimal with sequential double-dabble and
// streams the ASCII digits (plus optional CR LF) over a valid/ready link.
module module_als_ascii_sequencer
  import als_pkg::*;
#(
  parameter bit SEND_CRLF      = 1'b1,
  parameter bit SUPPRESS_ZEROS = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                START,
  input  logic [SAMPLE_W-1:0] SAMPLE,
  input  logic                TX_READY,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  output logic                busy,
  output logic                done
);

  state_t              state_q, state_d, first_st, load_st;
  logic [SAMPLE_W-1:0] bin_q, bin_d, bin_shift;
  logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj, bcd_shift;
  logic [2:0]          cnt_q, cnt_d;
  logic [7:0]          tx_data_q, tx_data_d, digit_ascii;
  logic                tx_valid_q, tx_valid_d;
  logic                xfer, load;
  logic [3:0]          nib;

  // Add-3 correction per nibble ahead of each shift
  for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                           : bcd_q[gi*4 +: 4];
  end

  assign {bcd_shift, bin_shift} = {bcd_adj, bin_q} << 1;
  assign xfer = tx_valid_q & TX_READY;

  always_comb begin
    first_st = ST_SEND_C;
    if (SUPPRESS_ZEROS && (bcd_shift[11:8] == 4'd0)) begin
      first_st = (bcd_shift[7:4] == 4'd0) ? ST_SEND_U : ST_SEND_D;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          bin_d   = SAMPLE;
          bcd_d   = '0;
          cnt_d   = 3'd0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        bin_d = bin_shift;
        bcd_d = bcd_shift;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = first_st;
      end
      ST_SEND_C:  if (xfer) state_d = ST_SEND_D;
      ST_SEND_D:  if (xfer) state_d = ST_SEND_U;
      ST_SEND_U:  if (xfer) state_d = SEND_CRLF ? ST_SEND_CR : ST_DONE;
      ST_SEND_CR: if (xfer) state_d = ST_SEND_LF;
      ST_SEND_LF: if (xfer) state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The byte register is filled on SEND entry, then refilled on each transfer
  always_comb begin
    load    = 1'b0;
    load_st = state_q;
    if (is_send(state_q) && !tx_valid_q) begin
      load = 1'b1;
    end else if (xfer && is_send(state_d)) begin
      load    = 1'b1;
      load_st = state_d;
    end
  end

  assign nib = (load_st == ST_SEND_C) ? bcd_q[11:8] :
               (load_st == ST_SEND_D) ? bcd_q[7:4]  : bcd_q[3:0];

  module_bcd2ascii u_bcd2ascii (
    .bcd_i   (nib),
    .ascii_o (digit_ascii)
  );

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (load) begin
      tx_valid_d = 1'b1;
      case (load_st)
        ST_SEND_CR: tx_data_d = ASCII_CR;
        ST_SEND_LF: tx_data_d = ASCII_LF;
        default:    tx_data_d = digit_ascii;
      endcase
    end else if (xfer) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= 3'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule
